// File: rtl/vga_controller_if.sv
// vga_controller_if
//   Bundles the DAC/connector side of the 640x480 VGA controller.
//   master : driven by vga_controller (RGB, syncs, blank, DAC sync/clock)
//   slave  : consumed by the board pins / bench
//   o_vga_r/g/b  8-bit colour
//   o_vga_hs     horizontal sync, active low
//   o_vga_vs     vertical sync, active low
//   o_vga_blank  BLANK_N, high in the visible area
//   o_vga_sync   SYNC_N to the DAC, tied low
//   o_vga_clk    DAC clock, inverted pixel clock
interface vga_controller_if;
    logic [7:0] o_vga_r;
    logic [7:0] o_vga_g;
    logic [7:0] o_vga_b;
    logic       o_vga_hs;
    logic       o_vga_vs;
    logic       o_vga_blank;
    logic       o_vga_sync;
    logic       o_vga_clk;

    modport master (
        output o_vga_r, o_vga_g, o_vga_b,
        output o_vga_hs, o_vga_vs, o_vga_blank,
        output o_vga_sync, o_vga_clk
    );

    modport slave (
        input o_vga_r, o_vga_g, o_vga_b,
        input o_vga_hs, o_vga_vs, o_vga_blank,
        input o_vga_sync, o_vga_clk
    );
endinterface

// File: rtl/vga_controller.sv
// vga_controller
//   640x480@60Hz timing generator and colour-bar test pattern for the
//   ADV7123 DAC, clocked by the 25 MHz pixel clock.
//   clk    in  pixel clock
//   rst_n  in  asynchronous active-low reset
//   vga    vga_controller_if.master (RGB, HS, VS, BLANK_N, SYNC_N, DAC clock)
//   Every registered output reflects the counter position of the previous
//   clock (one clock latency).
//   Optional build macro VGA_BOX_EN: adds a 32x32 white box that bounces
//   one pixel per axis per frame over the bars.
module vga_controller #(
    parameter int H_VIS = 640,
    parameter int H_FP  = 16,
    parameter int H_SW  = 96,
    parameter int H_BP  = 48,
    parameter int V_VIS = 480,
    parameter int V_FP  = 10,
    parameter int V_SW  = 2,
    parameter int V_BP  = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_controller_if.master vga
);
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SW - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SW - 1);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        line_end;
    logic        frame_end;
    logic        vis;
    logic        hs_n;
    logic        vs_n;
    logic [9:0]  bar;
    logic [23:0] bar_rgb;
    logic [23:0] pix_rgb;

    logic [23:0] rgb_q;
    logic        hs_q;
    logic        vs_q;
    logic        blank_q;

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + 10'd1;
            if (frame_end)
                v_cnt <= '0;
            else if (line_end)
                v_cnt <= v_cnt + 10'd1;
        end
    end

    assign vis  = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
    assign hs_n = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
    assign vs_n = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
    assign bar  = h_cnt / 10'd80;

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar)
            10'd0:   bar_rgb = 24'hFFFFFF;
            10'd1:   bar_rgb = 24'hFFFF00;
            10'd2:   bar_rgb = 24'h00FFFF;
            10'd3:   bar_rgb = 24'h00FF00;
            10'd4:   bar_rgb = 24'hFF00FF;
            10'd5:   bar_rgb = 24'hFF0000;
            10'd6:   bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

`ifdef VGA_BOX_EN
    localparam logic [9:0] BX_MAX = 10'd608;
    localparam logic [9:0] BY_MAX = 10'd448;

    logic [9:0] bx;
    logic [9:0] by;
    logic       dir_x;   // 1 = moving +x
    logic       dir_y;   // 1 = moving +y
    logic       in_box;

    // At an edge the direction flips and the same update steps back one pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx    <= '0;
            by    <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (frame_end) begin
            if (dir_x) begin
                if (bx == BX_MAX) begin
                    bx    <= bx - 10'd1;
                    dir_x <= 1'b0;
                end else begin
                    bx <= bx + 10'd1;
                end
            end else begin
                if (bx == 10'd0) begin
                    bx    <= 10'd1;
                    dir_x <= 1'b1;
                end else begin
                    bx <= bx - 10'd1;
                end
            end
            if (dir_y) begin
                if (by == BY_MAX) begin
                    by    <= by - 10'd1;
                    dir_y <= 1'b0;
                end else begin
                    by <= by + 10'd1;
                end
            end else begin
                if (by == 10'd0) begin
                    by    <= 10'd1;
                    dir_y <= 1'b1;
                end else begin
                    by <= by - 10'd1;
                end
            end
        end
    end

    assign in_box = (h_cnt >= bx) && (h_cnt < bx + 10'd32) &&
                    (v_cnt >= by) && (v_cnt < by + 10'd32);
    assign pix_rgb = !vis ? 24'h000000 : (in_box ? 24'hFFFFFF : bar_rgb);
`else
    assign pix_rgb = vis ? bar_rgb : 24'h000000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            rgb_q   <= pix_rgb;
            hs_q    <= hs_n;
            vs_q    <= vs_n;
            blank_q <= vis;
        end
    end

    assign vga.o_vga_r     = rgb_q[23:16];
    assign vga.o_vga_g     = rgb_q[15:8];
    assign vga.o_vga_b     = rgb_q[7:0];
    assign vga.o_vga_hs    = hs_q;
    assign vga.o_vga_vs    = vs_q;
    assign vga.o_vga_blank = blank_q;
    assign vga.o_vga_sync  = 1'b0;
    assign vga.o_vga_clk   = ~clk;
endmodule

// File: tb/tb_vga_controller.sv
module tb_vga_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    vga_controller_if vga();
    vga_controller dut (.clk(clk), .rst_n(rst_n), .vga(vga));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: linear pixel index within the frame, plus box state.
    int t;
    int bx, by, dx, dy;
    logic [9:0] jh, jv;
    logic [23:0] bars [8];

    initial begin
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    end

    function automatic logic [23:0] model_rgb(input int x, input int y);
        logic [23:0] c;
        if (x >= 640 || y >= 480) return 24'h0;
        c = bars[x / 80];
`ifdef VGA_BOX_EN
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) c = 24'hFFFFFF;
`endif
        return c;
    endfunction

    function automatic int bounce(input int p, inout int d, input int lim);
        int np;
        np = p + d;
        if (np < 0 || np > lim) begin
            d  = -d;
            np = p + d;
        end
        return np;
    endfunction

    task automatic model_reset();
        t = 0; bx = 0; by = 0; dx = 1; dy = 1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_rgb"}, 32'({vga.o_vga_r, vga.o_vga_g, vga.o_vga_b}), 32'h0);
        check({tag, "_hs"}, 32'(vga.o_vga_hs), 32'd1);
        check({tag, "_vs"}, 32'(vga.o_vga_vs), 32'd1);
        check({tag, "_blank"}, 32'(vga.o_vga_blank), 32'd0);
    endtask

    // One pixel clock: expected outputs come from the position before the edge.
    task automatic step();
        int x, y;
        logic [23:0] e_rgb;
        logic e_hs, e_vs, e_bl;
        x = t % 800;
        y = t / 800;
        e_rgb = model_rgb(x, y);
        e_hs  = !(x >= 656 && x < 656 + 96);
        e_vs  = !(y >= 490 && y < 490 + 2);
        e_bl  = (x < 640 && y < 480);
        if (t == 420000 - 1) begin
            bx = bounce(bx, dx, 608);
            by = bounce(by, dy, 448);
        end
        t = (t + 1) % 420000;
        @(posedge clk);
        #1;
        check("dac_clk_low", 32'(vga.o_vga_clk), 32'd0);
        @(negedge clk);
        check("rgb", 32'({vga.o_vga_r, vga.o_vga_g, vga.o_vga_b}), 32'(e_rgb));
        check("hs", 32'(vga.o_vga_hs), 32'(e_hs));
        check("vs", 32'(vga.o_vga_vs), 32'(e_vs));
        check("blank", 32'(vga.o_vga_blank), 32'(e_bl));
        check("sync", 32'(vga.o_vga_sync), 32'd0);
        check("dac_clk_high", 32'(vga.o_vga_clk), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called at a negedge: asynchronous assert, release two clocks later.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_outs("rst_hold");
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called at a negedge: move the counters to (h,v) without a clock edge.
    task automatic jump(input int h, input int v);
        jh = 10'(h);
        jv = 10'(v);
        force dut.h_cnt = jh;
        force dut.v_cnt = jv;
        #1;
        release dut.h_cnt;
        release dut.v_cnt;
        t = v * 800 + h;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outs("rst_init");
        rst_n = 1'b1;

        // First lines from reset: HS placement/width, bar colours, blanking.
        run(1700);

        // Mid-line reset around (300, 2), then restart from (0,0).
        run($urandom_range(100, 400));
        do_reset();
        run(900);

        // Vertical blanking, VS pulse and frame wrap.
        jump(780, 484);
        run(32500);

        // Several frame wraps to move the box (no-op without the box).
        for (int f = 0; f < 3; f++) begin
            jump(790, 524);
            run(20);
        end
        jump(0, 0);
        run(850);

`ifdef VGA_BOX_EN
        // Box at the right/bottom edges bounces back.
        force dut.bx = 10'd608;
        force dut.by = 10'd448;
        #1;
        release dut.bx;
        release dut.by;
        bx = 608;
        by = 448;
        jump(600, 447);
        run(1000);
        jump(790, 524);
        run(20);
        jump(590, 440);
        run(1000);
`endif

        // Random positions, with an occasional random-time reset.
        for (int k = 0; k < 8; k++) begin
            jump($urandom_range(0, 799), $urandom_range(0, 524));
            run($urandom_range(50, 600));
            if ($urandom_range(0, 3) == 0) begin
                do_reset();
                run($urandom_range(20, 200));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
